// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - playback control: song index, play/pause state and player restart pulse
// Prioritised next/prev/keypad/end-of-song handling with four end-of-song modes; all outputs registered.
module song_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              select_valid,
  input  logic [SONG_W-1:0] select_song,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player
);

  typedef enum logic {
    PAUSED  = 1'b0,
    PLAYING = 1'b1
  } state_t;

  localparam logic [1:0] MODE_STOP         = 2'd0;
  localparam logic [1:0] MODE_ADVANCE      = 2'd1;
  localparam logic [1:0] MODE_REPEAT_ONE   = 2'd2;
  localparam logic [1:0] MODE_ONCE_THROUGH = 2'd3;

  localparam logic [SONG_W-1:0] LAST  = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W:0]   COUNT = (SONG_W + 1)'(NUM_SONGS);

  state_t            state;
  state_t            state_nx;
  logic [SONG_W-1:0] song_nx;
  logic [SONG_W-1:0] song_inc;
  logic [SONG_W-1:0] song_dec;
  logic              pulse_nx;
  logic              select_ok;

  // Explicit wrap compares so non-power-of-two song counts never reach an invalid index.
  assign song_inc  = (song == LAST) ? '0 : song + 1'b1;
  assign song_dec  = (song == '0) ? LAST : song - 1'b1;
  assign select_ok = select_valid && ({1'b0, select_song} < COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PAUSED;
      song         <= '0;
      reset_player <= 1'b0;
    end else begin
      state        <= state_nx;
      song         <= song_nx;
      reset_player <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    song_nx  = song;
    pulse_nx = 1'b0;
    if (select_ok) begin
      song_nx  = select_song;
      state_nx = PLAYING;
      pulse_nx = 1'b1;
    end else if (prev_button) begin
      song_nx  = song_dec;
      state_nx = PAUSED;
      pulse_nx = 1'b1;
    end else if (next_button) begin
      song_nx  = song_inc;
      state_nx = PAUSED;
      pulse_nx = 1'b1;
    end else if (song_done && state == PLAYING) begin
      pulse_nx = 1'b1;
      case (mode)
        MODE_STOP: begin
          song_nx  = song_inc;
          state_nx = PAUSED;
        end
        MODE_ADVANCE:    song_nx = song_inc;
        MODE_REPEAT_ONE: song_nx = song;
        MODE_ONCE_THROUGH: begin
          // Last song wraps to the first and stops rather than looping forever.
          if (song == LAST) begin
            song_nx  = '0;
            state_nx = PAUSED;
          end else begin
            song_nx  = song_inc;
          end
        end
        default: song_nx = song;
      endcase
    end else if (play_button) begin
      state_nx = (state == PLAYING) ? PAUSED : PLAYING;
    end
  end

  always_comb begin
    play = (state == PLAYING);
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - randomized and directed bench for song_sequencer against an index/flag model
// Model tracks song as an integer with modulo arithmetic and play as a flag.
module tb_song_sequencer;

  localparam int N  = 5;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play_button = 1'b0;
  logic          next_button = 1'b0;
  logic          prev_button = 1'b0;
  logic          select_valid = 1'b0;
  logic [SW-1:0] select_song = '0;
  logic [1:0]    mode = 2'd0;
  logic          song_done = 1'b0;
  logic          play;
  logic [SW-1:0] song;
  logic          reset_player;

  int checks = 0;
  int failures = 0;
  int m_song = 0;
  int m_play = 0;
  int m_pulse = 0;

  song_sequencer #(.NUM_SONGS(N)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .select_valid(select_valid), .select_song(select_song),
    .mode(mode), .song_done(song_done), .play(play), .song(song), .reset_player(reset_player)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; the model advances by the documented rules, then outputs are compared.
  task automatic cycle(input string tag, input logic pb, input logic nb, input logic prb,
                       input logic sv, input int ss, input int md, input logic sd);
    play_button  = pb;
    next_button  = nb;
    prev_button  = prb;
    select_valid = sv;
    select_song  = SW'(ss);
    mode         = 2'(md);
    song_done    = sd;
    @(posedge clk);
    m_pulse = 0;
    if (sv && ss < N) begin
      m_song = ss; m_play = 1; m_pulse = 1;
    end else if (prb) begin
      m_song = (m_song + N - 1) % N; m_play = 0; m_pulse = 1;
    end else if (nb) begin
      m_song = (m_song + 1) % N; m_play = 0; m_pulse = 1;
    end else if (sd && m_play == 1) begin
      m_pulse = 1;
      if (md == 0) begin
        m_song = (m_song + 1) % N; m_play = 0;
      end else if (md == 1) begin
        m_song = (m_song + 1) % N;
      end else if (md == 3) begin
        if (m_song == N - 1) begin
          m_song = 0; m_play = 0;
        end else begin
          m_song = m_song + 1;
        end
      end
    end else if (pb) begin
      m_play = 1 - m_play;
    end
    #1;
    check({tag, ".play"}, int'(play), m_play);
    check({tag, ".song"}, int'(song), m_song);
    check({tag, ".pulse"}, int'(reset_player), m_pulse);
    play_button = 0; next_button = 0; prev_button = 0; select_valid = 0; song_done = 0;
  endtask

  initial begin
    #1;
    check("rst.play", int'(play), 0);
    check("rst.song", int'(song), 0);
    check("rst.pulse", int'(reset_player), 0);
    #12 reset = 1'b1;
    @(posedge clk); #1;
    check("rel.pulse", int'(reset_player), 0);

    for (int i = 0; i < 6; i++) begin
      cycle("next", 0, 1, 0, 0, 0, 0, 0);
      check("next.lit", int'(song), (i + 1) % N);
    end
    cycle("idle", 0, 0, 0, 0, 0, 0, 0);
    cycle("next", 0, 1, 0, 0, 0, 0, 0);
    cycle("next", 0, 1, 0, 0, 0, 0, 0);
    cycle("next", 0, 1, 0, 0, 0, 0, 0);
    cycle("next", 0, 1, 0, 0, 0, 0, 0);
    check("at0", int'(song), 0);
    cycle("prev", 0, 0, 1, 0, 0, 0, 0);
    check("prev_wrap", int'(song), 4);

    cycle("sel2", 0, 0, 0, 1, 2, 0, 0);
    cycle("stop", 0, 0, 0, 0, 0, 0, 1);
    check("stop.lit", int'(song) * 2 + int'(play), 3 * 2 + 0);
    cycle("sel2", 0, 0, 0, 1, 2, 0, 0);
    cycle("adv", 0, 0, 0, 0, 0, 1, 1);
    check("adv.lit", int'(song) * 2 + int'(play), 3 * 2 + 1);
    cycle("sel2", 0, 0, 0, 1, 2, 0, 0);
    cycle("rep", 0, 0, 0, 0, 0, 2, 1);
    check("rep.lit", int'(song) * 2 + int'(play), 2 * 2 + 1);
    cycle("sel4", 0, 0, 0, 1, 4, 0, 0);
    cycle("once_last", 0, 0, 0, 0, 0, 3, 1);
    check("once_last.lit", int'(song) * 2 + int'(play), 0);
    cycle("sel3", 0, 0, 0, 1, 3, 0, 0);
    cycle("once_mid", 0, 0, 0, 0, 0, 3, 1);
    check("once_mid.lit", int'(song) * 2 + int'(play), 4 * 2 + 1);

    cycle("sel0", 0, 0, 0, 1, 0, 0, 0);
    cycle("pause", 1, 0, 0, 0, 0, 0, 0);
    cycle("key3", 0, 0, 0, 1, 3, 0, 0);
    check("key3.lit", int'(song) * 2 + int'(play), 3 * 2 + 1);
    cycle("key6", 0, 0, 0, 1, 6, 0, 0);
    cycle("key6next", 0, 1, 0, 1, 6, 0, 0);
    check("key6next.lit", int'(song), 4);

    cycle("sel1", 0, 0, 0, 1, 1, 1, 0);
    cycle("simul", 1, 1, 0, 0, 0, 1, 1);
    check("simul.lit", int'(song) * 2 + int'(play), 2 * 2 + 0);
    cycle("done_paused", 0, 0, 0, 0, 0, 1, 1);

    cycle("sel3r", 0, 0, 0, 1, 3, 1, 0);
    reset = 1'b0;
    #1;
    m_song = 0; m_play = 0;
    check("async.play", int'(play), 0);
    check("async.song", int'(song), 0);
    check("async.pulse", int'(reset_player), 0);
    #2 reset = 1'b1;
    cycle("post_rst", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      cycle("rnd",
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Parametrised playback control unit for the music player: it tracks the current song index across `NUM_SONGS` songs and drives the play/pause state and the player-restart pulse. It supports next, previous and direct keypad selection, plus four end-of-song modes. It sits between the button/keypad front end and the song reader / note player, in place of the fixed four-song controller. All outputs are registered.

## Interface
- `NUM_SONGS`, default 4: number of songs; any value ≥ 2, power of two not required.
- `SONG_W`, default `$clog2(NUM_SONGS)`: width of the song index.

- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `play_button` input 1: one-cycle pulse; toggles play/pause.
- `next_button` input 1: one-cycle pulse; advance to the next song.
- `prev_button` input 1: one-cycle pulse; go back to the previous song.
- `select_valid` input 1: one-cycle pulse; keypad selection strobe.
- `select_song` input `SONG_W`: keypad song index, sampled when `select_valid`=1.
- `mode` input 2: end-of-song mode; 0 STOP, 1 ADVANCE, 2 REPEAT_ONE, 3 ONCE_THROUGH.
- `song_done` input 1: one-cycle pulse from the song reader when the current song finishes.
- `play` output 1: 1 while in PLAYING.
- `song` output `SONG_W`: current song index, always < `NUM_SONGS`.
- `reset_player` output 1: one-cycle pulse; restart the reader at the start of `song`.

## Operation
- The FSM has two states, PAUSED and PLAYING. A separate `song` register holds the current index.
- Per-cycle event priority, highest first. Only the highest-priority active event acts; the others are dropped.
  - 1. Valid select, meaning `select_valid`=1 and `select_song` < `NUM_SONGS`: `song`←`select_song`, state→PLAYING, pulse `reset_player`. An out-of-range select is ignored entirely and does not block lower-priority events.
  - 2. `prev_button`: `song`←`song`−1, wrapping 0→`NUM_SONGS`−1. State→PAUSED. Pulse.
  - 3. `next_button`: `song`←`song`+1, wrapping `NUM_SONGS`−1→0. State→PAUSED. Pulse.
  - 4. `song_done` while PLAYING, by mode:
    - STOP: `song`+1 with wrap, state→PAUSED, pulse.
    - ADVANCE: `song`+1 with wrap, stay PLAYING, pulse.
    - REPEAT_ONE: `song` unchanged, stay PLAYING, pulse.
    - ONCE_THROUGH: if `song` < `NUM_SONGS`−1, then `song`+1, stay PLAYING, pulse. Otherwise `song`←0, state→PAUSED, pulse.
  - 5. `play_button`: toggle PAUSED↔PLAYING. `song` unchanged, no pulse; the song resumes where it stopped.
- `song_done` while PAUSED is ignored.
- `mode` is sampled only on the cycle a `song_done` event is processed, so it may change at any time.
- Increment and decrement use explicit compares against `NUM_SONGS`−1 and 0, not natural `SONG_W` overflow. This is required for non-power-of-two `NUM_SONGS`.

## Timing
- Reset is asynchronous on the falling edge of `reset`. While `reset`=0: state=PAUSED, `play`=0, `song`=0, `reset_player`=0. No pulse is issued on reset release.
- Latency is 1 cycle. An event sampled at rising edge N appears on `play`, `song` and `reset_player` immediately after edge N.
- `reset_player` is high for exactly one cycle per qualifying event. Back-to-back events on consecutive cycles give back-to-back pulses.
- The new `song` value and the `reset_player` pulse are valid in the same cycle.
- Reset asserted mid-song or mid-pulse: outputs clear immediately, with no pulse completion.
- All inputs are synchronous to `clk`. Debouncing and one-pulse conversion are done upstream.

## Test plan
- `NUM_SONGS`=5, after reset:
  - Check `play`=0, `song`=0, `reset_player`=0.
  - 6× `next_button`: `song` goes 1,2,3,4,0,1, each with a 1-cycle `reset_player` and `play`=0.
  - `prev_button` from 0 → `song`=4.
- Mode STOP, PLAYING song 2, `song_done` → `song`=3, `play`=0, one pulse.
  - Repeat with mode ADVANCE → `song`=3, `play`=1.
  - Repeat with mode REPEAT_ONE → `song`=2, `play`=1, pulse.
- Mode ONCE_THROUGH, `NUM_SONGS`=5, playing song 4, `song_done` → `song`=0, `play`=0, pulse. From song 3: `song`=4, `play`=1.
- Keypad selection:
  - `select_valid` with `select_song`=3 while PAUSED on 0 → `song`=3, `play`=1, pulse.
  - `select_song`=6 → ignored: no pulse, state unchanged.
  - `select_song`=6 together with `next_button` → next acts.
- Simultaneous events:
  - `next_button`+`song_done`+`play_button` on the same cycle from PLAYING song 1 → `song`=2 (single step), `play`=0, one pulse.
  - `song_done` while PAUSED → no change.
- Assert `reset` low mid-song while PLAYING song 3 in the middle of a pulse cycle → outputs read 0/0/0 before the next clock edge. Release → no pulse.
